// File: rtl/ballot_controller_pkg.sv
// rtl/ballot_controller_pkg.sv - shared state codes and candidate codes for the ballot sequencer
package ballot_controller_pkg;

   localparam int NUM_CAND = 3;

   typedef logic [2:0] state_t;
   localparam state_t S_IDLE      = 3'd0;
   localparam state_t S_WAIT_AUTH = 3'd1;
   localparam state_t S_ARMED     = 3'd2;
   localparam state_t S_CONFIRM   = 3'd3;
   localparam state_t S_RELEASE   = 3'd4;
   localparam state_t S_CLOSED    = 3'd5;

   typedef logic [NUM_CAND-1:0] cand_t;
   localparam cand_t CAND_NONE = 3'b000;
   localparam cand_t CAND_1    = 3'b001;
   localparam cand_t CAND_2    = 3'b010;
   localparam cand_t CAND_3    = 3'b100;

   function automatic logic is_sole(input cand_t b);
      return (b != CAND_NONE) && ((b & (b - 1'b1)) == CAND_NONE);
   endfunction

endpackage

// File: rtl/ballot_controller_if.sv
// rtl/ballot_controller_if.sv - officer panel, voter buttons and voting_machine-facing pins
interface ballot_controller_if #(
   parameter int COUNT_W = 6
);
   logic               i_open;
   logic               i_authorize;
   logic               i_close;
   logic               i_candidate_1;
   logic               i_candidate_2;
   logic               i_candidate_3;
   logic               o_vote_1;
   logic               o_vote_2;
   logic               o_vote_3;
   logic               o_voting_over;
   logic               o_ready;
   logic               o_timeout;
   logic [COUNT_W-1:0] o_voter_count;

   modport master (
      output i_open, i_authorize, i_close, i_candidate_1, i_candidate_2, i_candidate_3,
      input  o_vote_1, o_vote_2, o_vote_3, o_voting_over, o_ready, o_timeout, o_voter_count
   );

   modport slave (
      input  i_open, i_authorize, i_close, i_candidate_1, i_candidate_2, i_candidate_3,
      output o_vote_1, o_vote_2, o_vote_3, o_voting_over, o_ready, o_timeout, o_voter_count
   );
endinterface

// File: rtl/ballot_controller_press_qualifier.sv
// rtl/ballot_controller_press_qualifier.sv - sole-button detection, candidate latch and hold counter
module press_qualifier
   import ballot_controller_pkg::*;
#(
   parameter int HOLD_CYCLES = 2
) (
   input  logic  clk,
   input  logic  rst,
   input  cand_t buttons,
   input  logic  armed,
   input  logic  confirming,
   output logic  sole,
   output logic  none,
   output logic  qualified,
   output logic  abort,
   output cand_t vote_code
);
   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

   cand_t             cand;
   logic [HOLD_W-1:0] hold;
   logic [HOLD_W-1:0] hold_inc;
   logic              start;
   logic              keep;

   // A first sole press counts as hold=1, so HOLD_CYCLES==1 qualifies on that same edge.
   always_comb begin
      sole      = is_sole(buttons);
      none      = (buttons == CAND_NONE);
      start     = armed && sole;
      keep      = confirming && (buttons == cand);
      hold_inc  = start ? HOLD_W'(1) : hold + 1'b1;
      qualified = (start || keep) && (hold_inc == HOLD_LAST);
      abort     = confirming && !keep;
      vote_code = start ? buttons : cand;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold <= '0;
         cand <= CAND_NONE;
      end else if (start || keep) begin
         hold <= hold_inc;
         cand <= vote_code;
      end else begin
         hold <= '0;
         cand <= CAND_NONE;
      end
   end

endmodule

// File: rtl/ballot_controller.sv
// rtl/ballot_controller.sv - session sequencer enforcing one qualified vote per authorization
module ballot_controller
   import ballot_controller_pkg::*;
#(
   parameter int HOLD_CYCLES    = 2,
   parameter int TIMEOUT_CYCLES = 100,
   parameter int MAX_VOTERS     = 63,
   parameter int COUNT_W        = 6
) (
   input logic clk,
   input logic rst,
   ballot_controller_if.slave bus
);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(MAX_VOTERS);

   state_t             state, state_d;
   logic [TMO_W-1:0]   tmo, tmo_d;
   logic               close_pend, close_pend_d;
   cand_t              buttons, vote_code, vote_d, vote_q;
   logic               sole, none, qualified, abort;
   logic               in_session, tmo_hit, close_eff;
   logic               over_d, ready_d, timeout_d;
   logic               over_q, ready_q, timeout_q;
   logic [COUNT_W-1:0] count_d, count_q;

   assign buttons    = {bus.i_candidate_3, bus.i_candidate_2, bus.i_candidate_1};
   assign in_session = (state == S_ARMED) || (state == S_CONFIRM);
   assign tmo_hit    = in_session && (tmo == TMO_LAST);
   assign close_eff  = close_pend || bus.i_close;

   press_qualifier #(.HOLD_CYCLES(HOLD_CYCLES)) u_qual (
      .clk        (clk),
      .rst        (rst),
      .buttons    (buttons),
      .armed      ((state == S_ARMED) && !tmo_hit),
      .confirming ((state == S_CONFIRM) && !tmo_hit),
      .sole       (sole),
      .none       (none),
      .qualified  (qualified),
      .abort      (abort),
      .vote_code  (vote_code)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         tmo        <= '0;
         close_pend <= 1'b0;
      end else begin
         state      <= state_d;
         tmo        <= tmo_d;
         close_pend <= close_pend_d;
      end
   end

   // Timeout is resolved before any press; a pending close diverts what would be a WAIT_AUTH entry.
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:      if (bus.i_open) state_d = S_WAIT_AUTH;
         S_WAIT_AUTH: begin
            if (bus.i_close)                   state_d = S_CLOSED;
            else if (bus.i_authorize && none)  state_d = S_ARMED;
         end
         S_ARMED: begin
            if (tmo_hit)        state_d = close_eff ? S_CLOSED : S_WAIT_AUTH;
            else if (qualified) state_d = S_RELEASE;
            else if (sole)      state_d = S_CONFIRM;
         end
         S_CONFIRM: begin
            if (tmo_hit)        state_d = close_eff ? S_CLOSED : S_WAIT_AUTH;
            else if (qualified) state_d = S_RELEASE;
            else if (abort)     state_d = S_ARMED;
         end
         S_RELEASE: begin
            if (none) state_d = (close_eff || count_q == COUNT_MAX) ? S_CLOSED : S_WAIT_AUTH;
         end
         S_CLOSED:    state_d = S_CLOSED;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      close_pend_d = close_pend;
      if (bus.i_close && (in_session || state == S_RELEASE)) close_pend_d = 1'b1;
      tmo_d     = (in_session && (state_d == S_ARMED || state_d == S_CONFIRM)) ? tmo + 1'b1 : '0;
      vote_d    = qualified ? vote_code : CAND_NONE;
      count_d   = (qualified && count_q != COUNT_MAX) ? count_q + 1'b1 : count_q;
      timeout_d = tmo_hit;
      ready_d   = (state_d == S_ARMED) || (state_d == S_CONFIRM);
      over_d    = (state_d == S_CLOSED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vote_q    <= CAND_NONE;
         count_q   <= '0;
         timeout_q <= 1'b0;
         ready_q   <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         vote_q    <= vote_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
         ready_q   <= ready_d;
         over_q    <= over_d;
      end
   end

   assign bus.o_vote_1      = vote_q[0];
   assign bus.o_vote_2      = vote_q[1];
   assign bus.o_vote_3      = vote_q[2];
   assign bus.o_voting_over = over_q;
   assign bus.o_ready       = ready_q;
   assign bus.o_timeout     = timeout_q;
   assign bus.o_voter_count = count_q;

endmodule
